// File: rtl/game_pkg.sv
// Shared game definitions: flow states and default timing constants used by
// the controller, display and ball logic.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam int unsigned LIVES_DEF  = 3;
  localparam int unsigned FRAME_RATE = 60;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Loadable, frame-tick-enabled down-counter that saturates at zero.
module frame_down_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load wins over tick; a tick at zero leaves the count at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/game_state_ctrl.sv
// Game flow controller: lives, new-game / play / serve-pause / game-over
// sequencing on frame ticks, plus the game-over blink and play enable.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int unsigned LIVES        = LIVES_DEF,
  parameter int unsigned PAUSE_FRAMES = 2 * FRAME_RATE,
  parameter int unsigned HOLD_FRAMES  = 3 * FRAME_RATE,
  parameter int unsigned BLINK_FRAMES = FRAME_RATE / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refr_tick,
  input  logic       start,
  input  logic       miss,
  output logic       game_on,
  output logic       game_over,
  output logic       over_blink,
  output logic       new_game,
  output logic [2:0] lives
);

  localparam int unsigned TW = $clog2(max_u(PAUSE_FRAMES, HOLD_FRAMES) + 1);
  localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);

  game_state_t state_q, state_d;
  logic [2:0]  lives_q, lives_d;
  logic        game_on_q, game_on_d;
  logic        game_over_q, game_over_d;
  logic        over_blink_q, over_blink_d;
  logic        new_game_q, new_game_d;
  logic        start_q;
  logic        start_rise;

  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic          timer_tick;
  logic [TW-1:0] timer_cnt;
  logic          timer_zero;

  logic          blink_load;
  logic          blink_tick;
  logic [BW-1:0] blink_cnt;
  logic          blink_zero;

  assign start_rise = start & ~start_q;

  frame_down_counter #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .tick     (timer_tick),
    .count    (timer_cnt),
    .zero     (timer_zero)
  );

  frame_down_counter #(.W(BW)) u_blink (
    .clk      (clk),
    .reset    (reset),
    .load     (blink_load),
    .load_val (BW'(BLINK_FRAMES)),
    .tick     (blink_tick),
    .count    (blink_cnt),
    .zero     (blink_zero)
  );

  assign blink_tick = (state_q == OVER) && refr_tick;

  // Next state, counter controls and registered-output next values.
  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    new_game_d   = 1'b0;
    over_blink_d = over_blink_q;
    timer_load   = 1'b0;
    timer_val    = '0;
    timer_tick   = 1'b0;
    blink_load   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d    = PLAY;
          lives_d    = 3'(LIVES);
          new_game_d = 1'b1;
        end
      end
      PLAY: begin
        // Timer is not ticked here, so a tick coincident with a miss
        // cannot eat into the freshly loaded pause/hold time.
        if (miss) begin
          timer_load = 1'b1;
          if (lives_q > 3'd1) begin
            state_d   = PAUSE;
            lives_d   = lives_q - 3'd1;
            timer_val = TW'(PAUSE_FRAMES);
          end else begin
            state_d      = OVER;
            lives_d      = '0;
            timer_val    = TW'(HOLD_FRAMES);
            over_blink_d = 1'b1;
            blink_load   = 1'b1;
          end
        end
      end
      PAUSE: begin
        timer_tick = refr_tick;
        if (refr_tick && (timer_cnt <= TW'(1))) begin
          state_d = PLAY;
        end
      end
      OVER: begin
        timer_tick = refr_tick;
        // Toggle on the tick that takes the blink count from 1 to 0 and
        // reload in the same edge, so the phase lasts exactly BLINK_FRAMES.
        if (refr_tick && ((blink_cnt == BW'(1)) || blink_zero)) begin
          blink_load   = 1'b1;
          over_blink_d = ~over_blink_q;
        end
        // Hold check uses the pre-decrement timer value.
        if (start_rise && timer_zero) begin
          state_d      = PLAY;
          lives_d      = 3'(LIVES);
          new_game_d   = 1'b1;
          over_blink_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    game_on_d   = (state_d == PLAY);
    game_over_d = (state_d == OVER);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      lives_q      <= 3'(LIVES);
      game_on_q    <= 1'b0;
      game_over_q  <= 1'b0;
      over_blink_q <= 1'b0;
      new_game_q   <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      game_on_q    <= game_on_d;
      game_over_q  <= game_over_d;
      over_blink_q <= over_blink_d;
      new_game_q   <= new_game_d;
      start_q      <= start;
    end
  end

  assign game_on    = game_on_q;
  assign game_over  = game_over_q;
  assign over_blink = over_blink_q;
  assign new_game   = new_game_q;
  assign lives      = lives_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed flow scenarios followed by random
// stimulus, all checked against a frame-counting reference model.
module tb_game_state_ctrl;

  localparam int unsigned P_LIVES = 3;
  localparam int unsigned P_PAUSE = 120;
  localparam int unsigned P_HOLD  = 180;
  localparam int unsigned P_BLINK = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       refr_tick = 1'b0;
  logic       start = 1'b0;
  logic       miss = 1'b0;
  logic       game_on;
  logic       game_over;
  logic       over_blink;
  logic       new_game;
  logic [2:0] lives;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 idle, 1 playing, 2 serving pause, 3 game over.
  int m_mode;
  int m_lives;
  int m_pause_ticks;
  int m_over_ticks;
  bit m_new_game;
  bit m_start_prev;

  game_state_ctrl #(
    .LIVES        (P_LIVES),
    .PAUSE_FRAMES (P_PAUSE),
    .HOLD_FRAMES  (P_HOLD),
    .BLINK_FRAMES (P_BLINK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .refr_tick  (refr_tick),
    .start      (start),
    .miss       (miss),
    .game_on    (game_on),
    .game_over  (game_over),
    .over_blink (over_blink),
    .new_game   (new_game),
    .lives      (lives)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode        = 0;
    m_lives       = P_LIVES;
    m_pause_ticks = 0;
    m_over_ticks  = 0;
    m_new_game    = 0;
    m_start_prev  = 0;
  endtask

  task automatic model_edge(input bit s, input bit m, input bit t);
    bit rise;
    rise = s && !m_start_prev;
    m_start_prev = s;
    m_new_game = 0;
    case (m_mode)
      0: if (rise) begin
        m_mode = 1; m_lives = P_LIVES; m_new_game = 1;
      end
      1: if (m) begin
        if (m_lives > 1) begin
          m_mode = 2; m_lives--; m_pause_ticks = 0;
        end else begin
          m_mode = 3; m_lives = 0; m_over_ticks = 0;
        end
      end
      2: if (t) begin
        m_pause_ticks++;
        if (m_pause_ticks == P_PAUSE) m_mode = 1;
      end
      default: begin
        if (rise && m_over_ticks >= P_HOLD) begin
          m_mode = 1; m_lives = P_LIVES; m_new_game = 1;
        end else if (t) begin
          m_over_ticks++;
        end
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    bit exp_blink;
    exp_blink = (m_mode == 3) && (((m_over_ticks / P_BLINK) % 2) == 0);
    check({tag, ".game_on"},    32'(game_on),    32'(m_mode == 1));
    check({tag, ".game_over"},  32'(game_over),  32'(m_mode == 3));
    check({tag, ".over_blink"}, 32'(over_blink), 32'(exp_blink));
    check({tag, ".new_game"},   32'(new_game),   32'(m_new_game));
    check({tag, ".lives"},      32'(lives),      32'(m_lives));
  endtask

  // One clock: drive inputs, advance the model on the edge, check after it.
  task automatic step(input string tag, input bit s, input bit m, input bit t);
    start = s; miss = m; refr_tick = t;
    @(posedge clk);
    model_edge(s, m, t);
    #1;
    check_all(tag);
  endtask

  task automatic ticks(input string tag, input int n, input bit s);
    for (int i = 0; i < n; i++) step(tag, s, 1'b0, 1'b1);
  endtask

  task automatic async_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #2;
    reset = 1'b0;
    check_all({tag, "_rel"});
  endtask

  initial begin
    int pulses;
    bit s_lvl;
    bit r_miss;
    bit r_tick;

    model_reset();
    #2;
    async_reset("por");
    check("por.lives_const", 32'(lives), 32'd3);

    // Start held high for 10 cycles gives a single new_game pulse.
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step("hold_start", 1'b1, 1'b0, 1'b0);
      if (new_game) pulses++;
    end
    check("hold_start.pulses", 32'(pulses), 32'd1);
    step("rel_start", 1'b0, 1'b0, 1'b0);

    // Miss from 3 lives, then a miss during the pause is ignored.
    step("miss1", 1'b0, 1'b1, 1'b0);
    check("miss1.lives_const", 32'(lives), 32'd2);
    ticks("pause_a", 60, 1'b0);
    step("pause_miss", 1'b0, 1'b1, 1'b0);
    ticks("pause_b", 59, 1'b0);
    check("pause119.game_on", 32'(game_on), 32'd0);
    step("pause120", 1'b0, 1'b0, 1'b1);
    check("pause120.game_on", 32'(game_on), 32'd1);
    check("pause120.lives", 32'(lives), 32'd2);

    // Reset mid-PLAY with two lives left.
    step("play_idle", 1'b0, 1'b0, 1'b0);
    async_reset("mid_reset");

    // New game and three misses to game over; second miss lands on a tick.
    step("start2", 1'b1, 1'b0, 1'b0);
    step("start2_rel", 1'b0, 1'b0, 1'b0);
    step("m1", 1'b0, 1'b1, 1'b0);
    ticks("p1", P_PAUSE, 1'b0);
    step("m2_tick", 1'b0, 1'b1, 1'b1);
    ticks("p2", P_PAUSE - 1, 1'b0);
    check("p2_119.game_on", 32'(game_on), 32'd0);
    step("p2_120", 1'b0, 1'b0, 1'b1);
    check("p2_120.game_on", 32'(game_on), 32'd1);
    step("m3", 1'b0, 1'b1, 1'b0);
    check("m3.game_over", 32'(game_over), 32'd1);
    check("m3.over_blink", 32'(over_blink), 32'd1);
    check("m3.lives", 32'(lives), 32'd0);

    // Blink phases and hold window.
    ticks("over_a", 30, 1'b0);
    check("blink30", 32'(over_blink), 32'd0);
    ticks("over_b", 30, 1'b0);
    check("blink60", 32'(over_blink), 32'd1);
    ticks("over_c", 30, 1'b0);
    check("blink90", 32'(over_blink), 32'd0);
    ticks("over_d", 88, 1'b0);
    step("start_t179", 1'b1, 1'b0, 1'b1);
    check("start_t179.game_over", 32'(game_over), 32'd1);
    step("rel_t179", 1'b0, 1'b0, 1'b0);
    step("start_t180", 1'b1, 1'b0, 1'b1);
    check("start_t180.game_over", 32'(game_over), 32'd1);
    step("rel_t180", 1'b0, 1'b0, 1'b0);
    step("idle_over", 1'b0, 1'b0, 1'b0);
    step("start_ok", 1'b1, 1'b0, 1'b0);
    check("start_ok.new_game", 32'(new_game), 32'd1);
    check("start_ok.game_over", 32'(game_over), 32'd0);
    check("start_ok.over_blink", 32'(over_blink), 32'd0);
    check("start_ok.lives", 32'(lives), 32'd3);
    step("start_ok_rel", 1'b0, 1'b0, 1'b0);

    // Random play against the model.
    s_lvl = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 15) == 0) s_lvl = ~s_lvl;
      r_miss = ($urandom_range(0, 39) == 0);
      r_tick = ($urandom_range(0, 1) == 0);
      step("rand", s_lvl, r_miss, r_tick);
    end

    start = 1'b0; miss = 1'b0; refr_tick = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
# game_state_ctrl

Top-level game flow controller for the VGA game. It tracks lives, sequences new-game, play, serve-pause and game-over phases on frame ticks, and drives the registered `game_over` level consumed by the game-over text overlay. It also produces a blink enable for that overlay and a `game_on` gate for the ball/paddle logic. It sits between the collision/frame-tick logic and the display stages.

## Interface
Parameters:
- `LIVES`, 3: lives per game (1..7).
- `PAUSE_FRAMES`, 120: frame ticks spent in serve pause after a lost life (≥1).
- `HOLD_FRAMES`, 180: frame ticks in game-over before `start` is accepted (≥1).
- `BLINK_FRAMES`, 30: frame ticks per `over_blink` half-period (≥1).

Ports:
- `clk`  in  1  pixel clock; one clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `refr_tick`  in  1  one-cycle pulse per frame (start of vertical blank).
- `start`  in  1  debounced, synchronous start button level.
- `miss`  in  1  one-cycle pulse: ball left the field.
- `game_on`  out  1  play enable for ball/paddle motion.
- `game_over`  out  1  level, high in OVER.
- `over_blink`  out  1  blink phase for game-over text; 0 outside OVER.
- `new_game`  out  1  one-cycle pulse when a game starts (clears score).
- `lives`  out  3  remaining lives, unsigned.

## Operation
- States: IDLE, PLAY, PAUSE, OVER. All outputs are registered.
- Reset values: state=IDLE, lives=LIVES, game_on=0, game_over=0, over_blink=0, new_game=0, timer=0, start_q=0.
- Start edge: `start_rise = start & ~start_q`. `start_q` is registered every cycle. A held button never re-triggers.
- IDLE: game_on=0. `start_rise` → PLAY, lives←LIVES, new_game=1 for one cycle.
- PLAY: game_on=1. `miss` with lives>1 → PAUSE, lives←lives−1, timer←PAUSE_FRAMES. `miss` with lives==1 → OVER, lives←0, timer←HOLD_FRAMES, over_blink←1, blink counter←BLINK_FRAMES. `start` is ignored.
- PAUSE: game_on=0. Each `refr_tick` decrements timer. A `refr_tick` with timer==1 → PLAY. `miss` and `start` are ignored.
- OVER: game_over=1, game_on=0.
  - Each `refr_tick` decrements timer while timer>0.
  - Each `refr_tick` decrements the blink counter. On reaching 0, over_blink toggles and the counter reloads BLINK_FRAMES.
  - `start_rise` with timer==0 → PLAY, lives←LIVES, new_game=1, over_blink←0. `start_rise` while timer>0 is ignored; it is not remembered.
- Simultaneous events:
  - `miss` and `refr_tick` in PLAY: the miss is taken, and the tick does not decrement the freshly loaded timer.
  - `start_rise` and `refr_tick` on the OVER cycle where timer goes 1→0: start is ignored, because the check uses the pre-decrement value.
- `lives` never underflows. Counter widths: timer is `$clog2(max(PAUSE_FRAMES,HOLD_FRAMES)+1)` bits, unsigned, saturating at 0.
- Reset asserted mid-game returns all state to reset values immediately, asynchronously.

## Timing
- Input-to-output latency is one cycle. An event sampled at edge N is visible on outputs after edge N.
- `new_game` is high exactly one cycle, coincident with the first cycle of `game_on`=1.
- PAUSE length is exactly PAUSE_FRAMES frame ticks. `game_on` rises the cycle after the PAUSE_FRAMES-th tick.
- OVER: start is accepted from the cycle after the HOLD_FRAMES-th tick.
- `over_blink` is first high the cycle after entering OVER. It toggles the cycle after every BLINK_FRAMES-th tick.

## Structure
- Shared package `game_pkg`: `game_state_t` enum {IDLE, PLAY, PAUSE, OVER} and default constants `LIVES_DEF`, `FRAME_RATE` (60). The display and ball logic import the same package.
- One natural sub-module: `frame_down_counter`. It is a loadable, tick-enabled, saturating down-counter with a `zero` flag. It is instantiated twice: the phase timer and the blink counter.
- Everything else is a single FSM always_ff plus next-state always_comb.

## Test plan
- Reset mid-PLAY with lives=2 → next cycle state IDLE, lives=3, game_on=0, game_over=0, all outputs at reset values.
- IDLE, `start` held high 10 cycles → exactly one `new_game` pulse, game_on=1 one cycle after the rise, lives=3.
- PLAY lives=3, `miss` pulse → lives=2, game_on=0. After exactly 120 `refr_tick`s, game_on=1. A `miss` during the pause leaves lives=2.
- Three misses (each followed by the pause) → lives=0, game_over=1, over_blink=1. over_blink toggles after ticks 30, 60, 90.
- OVER: `start_rise` at tick 179 is ignored. `start_rise` issued together with tick 180 is ignored. `start_rise` after tick 180 → PLAY, lives=3, new_game pulse, game_over=0, over_blink=0.
- `miss` coincident with `refr_tick` in PLAY → PAUSE timer reads 120 and is not decremented that cycle.
